// File: rtl/md_sixbutton_encoder.sv
// Mega Drive six-button pad encoder: follows console TH (p7) and multiplexes
// twelve active-low buttons onto DB9 pins 1,2,3,4,6,9 using the TH-cycle protocol.
module md_sixbutton_encoder #(
  parameter int unsigned TIMEOUT_CYCLES = 30000
) (
  input  logic clk,
  input  logic rst,
  input  logic p7,
  input  logic up,
  input  logic dw,
  input  logic lf,
  input  logic rg,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic st,
  input  logic x,
  input  logic y,
  input  logic z,
  input  logic md,
  output logic p1,
  output logic p2,
  output logic p3,
  output logic p4,
  output logic p6,
  output logic p9
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    CYC0 = 3'd0,
    CYC1 = 3'd1,
    CYC2 = 3'd2,
    CYC3 = 3'd3,
    CYC4 = 3'd4,
    CYC5 = 3'd5
  } cyc_t;

  cyc_t          state;
  cyc_t          state_nxt;
  logic          th_s1;
  logic          th_s2;
  logic          th_dly;
  logic          th_rise;
  logic          th_edge;
  logic          timeout;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;

  // TH synchronizer plus delayed copy for edge detection; idle level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      th_s1  <= 1'b1;
      th_s2  <= 1'b1;
      th_dly <= 1'b1;
    end else begin
      th_s1  <= p7;
      th_s2  <= th_s1;
      th_dly <= th_s2;
    end
  end

  assign th_rise = th_s2 & ~th_dly;
  assign th_edge = th_s2 ^ th_dly;
  // An edge in the same cycle as expiry wins over the timeout
  assign timeout = ~th_edge && (timer == TW'(TIMEOUT_CYCLES - 1));

  // Idle timer: restarts on any TH edge, parks at TIMEOUT_CYCLES until the next one
  always_comb begin
    timer_nxt = timer;
    if (th_edge) begin
      timer_nxt = '0;
    end else if (timer != TW'(TIMEOUT_CYCLES)) begin
      timer_nxt = timer + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else begin
      timer <= timer_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CYC0;
    end else begin
      state <= state_nxt;
    end
  end

  // TH-cycle position: advance on each rising edge, saturate at 5, clear on timeout
  always_comb begin
    state_nxt = state;
    if (th_rise) begin
      case (state)
        CYC0:    state_nxt = CYC1;
        CYC1:    state_nxt = CYC2;
        CYC2:    state_nxt = CYC3;
        CYC3:    state_nxt = CYC4;
        CYC4:    state_nxt = CYC5;
        CYC5:    state_nxt = CYC5;
        default: state_nxt = CYC0;
      endcase
    end else if (timeout) begin
      state_nxt = CYC0;
    end
  end

  // Pin mux keys off raw p7 so group switching has no clock latency
  always_comb begin
    {p1, p2, p3, p4} = {up, dw, lf, rg};
    p6 = b;
    p9 = c;
    if (p7) begin
      if (state == CYC4) begin
        {p1, p2, p3, p4} = {z, y, x, md};
      end
    end else begin
      p6 = a;
      p9 = st;
      case (state)
        CYC3:    {p1, p2, p3, p4} = 4'b0000;
        CYC4:    {p1, p2, p3, p4} = 4'b1111;
        default: {p1, p2, p3, p4} = {up, dw, 2'b00};
      endcase
    end
  end

endmodule

// File: tb/tb_md_sixbutton_encoder.sv
// Self-checking bench for md_sixbutton_encoder: directed protocol scenarios plus
// randomized TH/button traffic checked against a latency-level model of the pad.
`timescale 1ns/1ps
module tb_md_sixbutton_encoder;

  localparam int T = 30000;

  logic clk = 1'b0;
  logic rst;
  logic p7;
  logic up, dw, lf, rg, a, b, c, st, x, y, z, md;
  logic p1, p2, p3, p4, p6, p9;

  int   n_pass = 0;
  int   n_total = 0;
  int   model_cnt = 0;
  int   since = 0;
  logic pending_rise = 1'b0;

  md_sixbutton_encoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .p7(p7),
    .up(up), .dw(dw), .lf(lf), .rg(rg),
    .a(a), .b(b), .c(c), .st(st),
    .x(x), .y(y), .z(z), .md(md),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p6(p6), .p9(p9)
  );

  always #25 clk = ~clk;

  function automatic logic [5:0] obs();
    return {p1, p2, p3, p4, p6, p9};
  endfunction

  // Pin table for a given TH level and cycle position
  function automatic logic [5:0] model_pins(input logic th, input int k);
    logic [3:0] d;
    if (th) d = (k == 4) ? {z, y, x, md} : {up, dw, lf, rg};
    else if (k == 3) d = 4'b0000;
    else if (k == 4) d = 4'b1111;
    else d = {up, dw, 2'b00};
    return th ? {d, b, c} : {d, a, st};
  endfunction

  // Advance n cycles; cnt follows a rise 3 cycles later and clears T+3 cycles after the last edge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      since++;
      if (since == 3 && pending_rise) begin
        model_cnt = (model_cnt < 5) ? model_cnt + 1 : 5;
        pending_rise = 1'b0;
      end
      if (since == T + 3) model_cnt = 0;
    end
  endtask

  task automatic set_p7(input logic v);
    if (v !== p7) begin
      since = 0;
      pending_rise = v;
    end
    p7 = v;
  endtask

  task automatic set_btn(input logic [11:0] v);
    {up, dw, lf, rg, a, b, c, st, x, y, z, md} = v;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_cnt = 0;
    pending_rise = 1'b0;
    since = 0;
    run(2);
    rst = 1'b0;
    run(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    p7 = 1'b1;
    set_btn(12'hFFF);
    run(3);
    n_total++;
    if (obs() !== 6'b111111) $display("FAIL reset_high: got %b want %b", obs(), 6'b111111);
    else n_pass++;
    rst = 1'b0;
    run(3);
    n_total++;
    if (obs() !== 6'b111111) $display("FAIL post_reset_high: got %b want %b", obs(), 6'b111111);
    else n_pass++;
    set_p7(1'b0);
    #1;
    n_total++;
    if (obs() !== 6'b110011) $display("FAIL reset_low: got %b want %b", obs(), 6'b110011);
    else n_pass++;
    run(5);
  endtask

  task automatic test_basic_mapping();
    set_btn(12'b1111_0110_1111);
    #1;
    n_total++;
    if (obs() !== 6'b110000) $display("FAIL low_a_start: got %b want %b", obs(), 6'b110000);
    else n_pass++;
    set_btn(12'b1111_1011_1111);
    set_p7(1'b1);
    #1;
    n_total++;
    if (obs() !== 6'b111101) $display("FAIL high_b: got %b want %b", obs(), 6'b111101);
    else n_pass++;
    run(10);
  endtask

  task automatic test_six_button_sequence();
    logic [5:0] hi_exp [4] = '{6'b011111, 6'b011111, 6'b011111, 6'b110111};
    logic [5:0] lo_exp [4] = '{6'b010011, 6'b010011, 6'b000011, 6'b111111};
    set_p7(1'b0);
    set_btn(12'b0111_1111_0111);
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      set_p7(1'b1);
      #1;
      n_total++;
      if (obs() !== 6'b011111) $display("FAIL six_high_early%0d: got %b want %b", k + 1, obs(), 6'b011111);
      else n_pass++;
      run(20);
      n_total++;
      if (obs() !== hi_exp[k]) $display("FAIL six_high%0d: got %b want %b", k + 1, obs(), hi_exp[k]);
      else n_pass++;
      set_p7(1'b0);
      run(20);
      n_total++;
      if (obs() !== lo_exp[k]) $display("FAIL six_low%0d: got %b want %b", k + 1, obs(), lo_exp[k]);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    logic [5:0] e;
    set_p7(1'b0);
    pulse_reset();
    for (int k = 1; k <= 9; k++) begin
      set_btn(12'($urandom));
      set_p7(1'b1);
      run(20);
      e = model_pins(1'b1, model_cnt);
      if (k >= 5) begin
        n_total++;
        if (obs() !== e) $display("FAIL sat_high%0d: got %b want %b", k, obs(), e);
        else n_pass++;
      end
      set_p7(1'b0);
      run(20);
      e = model_pins(1'b0, model_cnt);
      if (k >= 5) begin
        n_total++;
        if (obs() !== e) $display("FAIL sat_low%0d: got %b want %b", k, obs(), e);
        else n_pass++;
      end
    end
    n_total++;
    if (obs() !== {up, dw, 2'b00, a, st}) $display("FAIL sat_final: got %b want %b", obs(), {up, dw, 2'b00, a, st});
    else n_pass++;
  endtask

  task automatic test_timeout();
    set_btn(12'hFFF);
    set_p7(1'b0);
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      set_p7(1'b1);
      run(20);
      set_p7(1'b0);
      if (k < 2) run(20);
    end
    run(T + 2);
    n_total++;
    if (obs() !== 6'b000011) $display("FAIL idle_short_keeps_cnt: got %b want %b", obs(), 6'b000011);
    else n_pass++;
    run(1);
    n_total++;
    if (obs() !== 6'b110011) $display("FAIL idle_timeout_clears: got %b want %b", obs(), 6'b110011);
    else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      set_p7(1'b1);
      run(20);
      set_p7(1'b0);
      run(20);
      n_total++;
      if (obs() !== ((k == 3) ? 6'b000011 : 6'b110011))
        $display("FAIL after_timeout_low%0d: got %b want %b", k, obs(), (k == 3) ? 6'b000011 : 6'b110011);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sequence();
    set_btn(12'b0111_1111_0111);
    set_p7(1'b0);
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      set_p7(1'b1);
      run(20);
      set_p7(1'b0);
      run(20);
    end
    set_p7(1'b1);
    run(10);
    n_total++;
    if (obs() !== 6'b110111) $display("FAIL mid_high4: got %b want %b", obs(), 6'b110111);
    else n_pass++;
    rst = 1'b1;
    model_cnt = 0;
    pending_rise = 1'b0;
    #1;
    n_total++;
    if (obs() !== 6'b011111) $display("FAIL mid_reset_async: got %b want %b", obs(), 6'b011111);
    else n_pass++;
    run(2);
    rst = 1'b0;
    run(5);
    n_total++;
    if (obs() !== 6'b011111) $display("FAIL mid_reset_release: got %b want %b", obs(), 6'b011111);
    else n_pass++;
    set_p7(1'b0);
    run(20);
    for (int k = 1; k <= 3; k++) begin
      set_p7(1'b1);
      run(20);
      set_p7(1'b0);
      run(20);
      n_total++;
      if (obs() !== ((k == 3) ? 6'b000011 : 6'b010011))
        $display("FAIL restart_low%0d: got %b want %b", k, obs(), (k == 3) ? 6'b000011 : 6'b010011);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [5:0] e;
    int len;
    set_p7(1'b0);
    pulse_reset();
    for (int k = 0; k < 40; k++) begin
      set_btn(12'($urandom));
      set_p7(~p7);
      #1;
      e = model_pins(p7, model_cnt);
      n_total++;
      if (obs() !== e) $display("FAIL rnd_edge%0d: got %b want %b cnt %0d", k, obs(), e, model_cnt);
      else n_pass++;
      len = int'($urandom_range(30, 4));
      run(len);
      set_btn(12'($urandom));
      #1;
      e = model_pins(p7, model_cnt);
      n_total++;
      if (obs() !== e) $display("FAIL rnd_settled%0d: got %b want %b cnt %0d", k, obs(), e, model_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_mapping();
    test_six_button_sequence();
    test_saturation();
    test_timeout();
    test_reset_mid_sequence();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
